// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier with integrated control.
// One Booth step (add/subtract then arithmetic shift) per clock on an
// (N+1)-bit A/M/Q datapath, so signed and unsigned operands share one engine.
// The product is registered on the edge that enters DONE, and it is held there.
module booth_mult_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicando,
  input  logic [N-1:0]   multiplicador,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);

  // One extra bit lets an unsigned operand be treated as a non-negative
  // signed value, so the same signed Booth recoding covers both modes.
  localparam int W  = N + 1;
  localparam int CW = $clog2(N + 2);

  // The counter holds the index of the step being executed (0 .. W-1).
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    m_q;
  logic [W-1:0]    q_q;
  logic            qm1_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [2*N-1:0]  result_q;

  logic            accept_s;
  logic [W-1:0]    m_load_s;
  logic [W-1:0]    q_load_s;
  logic [W-1:0]    a_sum_s;
  logic [W-1:0]    a_d;
  logic [W-1:0]    q_d;
  logic            qm1_d;
  logic [2*N-1:0]  result_d;

  // Widen an operand by one bit: replicate the MSB in signed mode,
  // insert a zero in unsigned mode.
  function automatic logic [W-1:0] extend_operand(input logic [N-1:0] value,
                                                  input logic         is_signed);
    extend_operand = {is_signed & value[N-1], value};
  endfunction

  // A request is only honoured when no product is being computed.
  always_comb begin
    accept_s = 1'b0;
    if (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Operand extension applied at the accepting edge.
  always_comb begin
    m_load_s = extend_operand(multiplicando, signed_mode);
    q_load_s = extend_operand(multiplicador, signed_mode);
  end

  // Booth step: recode {Q[0], q-1} into add/subtract/hold, then shift
  // {A,Q,q-1} right arithmetically by one; the carry-out of A is dropped.
  always_comb begin
    a_sum_s = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum_s = a_q + m_q;
      2'b10:   a_sum_s = a_q - m_q;
      default: a_sum_s = a_q;
    endcase
    a_d   = {a_sum_s[W-1], a_sum_s[W-1:1]};
    q_d   = {a_sum_s[0], q_q[W-1:1]};
    qm1_d = q_q[0];
  end

  // The 2N-bit product is the low part of {A,Q} after the final step;
  // the top two bits of A are pure sign copies for any legal product.
  always_comb begin
    result_d = {a_d[N-2:0], q_d};
  end

  // Control FSM together with the datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      a_q      <= {W{1'b0}};
      m_q      <= {W{1'b0}};
      q_q      <= {W{1'b0}};
      qm1_q    <= 1'b0;
      cnt_q    <= CNT_ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {(2*N){1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (accept_s) begin
            a_q     <= {W{1'b0}};
            m_q     <= m_load_s;
            q_q     <= q_load_s;
            qm1_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_STEP) begin
            result_q <= result_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_DONE;
          end else begin
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_CALC;
          end
        end

        ST_DONE: begin
          // done lasts exactly one cycle; a waiting request starts at once.
          done_q <= 1'b0;
          if (accept_s) begin
            a_q     <= {W{1'b0}};
            m_q     <= m_load_s;
            q_q     <= q_load_s;
            qm1_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed stimulus for an N=8 and an N=3 instance.
// Issued requests push their expected product into a per-instance queue;
// monitors pop and compare whenever done is seen.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic        sm8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] res8;

  logic        start3;
  logic        sm3;
  logic [2:0]  a3;
  logic [2:0]  b3;
  logic        busy3;
  logic        done3;
  logic [5:0]  res3;

  int errors;
  int checks;

  logic [15:0] exp8_q[$];
  logic [5:0]  exp3_q[$];

  booth_mult_seq #(.N(8)) u_dut8 (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start8),
    .signed_mode   (sm8),
    .multiplicando (a8),
    .multiplicador (b8),
    .busy          (busy8),
    .done          (done8),
    .result        (res8)
  );

  booth_mult_seq #(.N(3)) u_dut3 (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start3),
    .signed_mode   (sm3),
    .multiplicando (a3),
    .multiplicador (b3),
    .busy          (busy3),
    .done          (done3),
    .result        (res3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference product for N=3 using plain integer multiplication.
  function automatic logic [5:0] ref3(input logic [2:0] a, input logic [2:0] b, input logic s);
    logic signed [31:0] pa;
    logic signed [31:0] pb;
    logic signed [31:0] p;
    pa = s ? 32'($signed(a)) : 32'(a);
    pb = s ? 32'($signed(b)) : 32'(b);
    p  = pa * pb;
    return p[5:0];
  endfunction

  // Monitor N=8: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL res8_unexpected_done actual=%0h expected=none", res8);
      end else begin
        logic [15:0] e;
        e = exp8_q.pop_front();
        if (res8 !== e) begin
          errors++;
          $display("FAIL res8 actual=%0h expected=%0h", res8, e);
        end
      end
    end
  end

  // Monitor N=3: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      checks++;
      if (exp3_q.size() == 0) begin
        errors++;
        $display("FAIL res3_unexpected_done actual=%0h expected=none", res3);
      end else begin
        logic [5:0] e;
        e = exp3_q.pop_front();
        if (res3 !== e) begin
          errors++;
          $display("FAIL res3 actual=%0h expected=%0h", res3, e);
        end
      end
    end
  end

  // Issue one N=8 request; start is left high unless 'last' (back-to-back use).
  // Must be called away from a rising edge; returns #1 after the done edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input logic last);
    int k;
    logic seen;
    start8 = 1'b1;
    sm8    = s;
    a8     = a;
    b8     = b;
    exp8_q.push_back(exp);
    @(posedge clk);
    #1;
    if (last) start8 = 1'b0;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) chk("busy8_in_calc", 32'(busy8), 32'd1);
      if (done8 === 1'b1) seen = 1'b1;
    end
    chk("done8_latency", 32'(k), 32'd9);
    chk("busy8_at_done", 32'(busy8), 32'd0);
  endtask

  // Issue one N=3 request and wait for its done pulse.
  task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic s);
    int k;
    logic seen;
    start3 = 1'b1;
    sm3    = s;
    a3     = a;
    b3     = b;
    exp3_q.push_back(ref3(a, b, s));
    @(posedge clk);
    #1;
    start3 = 1'b0;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      @(posedge clk);
      #1;
      k++;
      if (done3 === 1'b1) seen = 1'b1;
    end
    chk("done3_latency", 32'(k), 32'd4);
  endtask

  // Global time limit so the run can never hang.
  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
    start3 = 1'b0; sm3 = 1'b0; a3 = 3'd0; b3 = 3'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_done", 32'(done8), 32'd0);
    chk("reset_result", 32'(res8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed products.
    issue8(8'd7,   8'hFD, 1'b1, 16'hFFEB, 1'b1);
    issue8(8'hFF,  8'hFF, 1'b0, 16'hFE01, 1'b1);
    issue8(8'hFF,  8'hFF, 1'b1, 16'h0001, 1'b1);
    issue8(8'h80,  8'h80, 1'b1, 16'h4000, 1'b1);
    issue8(8'h80,  8'h7F, 1'b1, 16'hC080, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("result_held", 32'(res8), 32'hC080);

    // Ignored start mid-CALC: only one done, first result kept.
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd5; b8 = 8'd6;
    exp8_q.push_back(16'h001E);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done8 === 1'b1) pulses++;
    end
    chk("ignored_start_pulses", 32'(pulses), 32'd1);
    chk("ignored_start_result", 32'(res8), 32'h001E);

    // Back-to-back with start held high.
    @(negedge clk);
    issue8(8'd3,   8'd5,  1'b0, 16'h000F, 1'b0);
    issue8(8'hFF,  8'd2,  1'b1, 16'hFFFE, 1'b0);
    issue8(8'h10,  8'h10, 1'b0, 16'h0100, 1'b0);
    issue8(8'h81,  8'd3,  1'b1, 16'hFE83, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle_busy", 32'(busy8), 32'd0);

    // Reset during CALC: outputs clear immediately, nothing partial kept.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'd3; b8 = 8'd4;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy8), 32'd0);
    chk("midreset_done", 32'(done8), 32'd0);
    chk("midreset_result", 32'(res8), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue8(8'd12, 8'd11, 1'b0, 16'h0084, 1'b1);

    // N=3 exhaustive in both modes.
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          issue3(3'(a), 3'(b), (s == 1) ? 1'b1 : 1'b0);
          @(negedge clk);
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("exp8_queue_drained", 32'(exp8_q.size()), 32'd0);
    chk("exp3_queue_drained", 32'(exp3_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
